// File: rtl/fetch_sched.sv
// Fetch-stage sequencing FSM: owns the fetch PC and picks advance / hold / bubble / redirect.
// Optional `FETCH_SCHED_PERF_EN adds O_StallCycles and O_BubbleCycles counters.
module fetch_sched #(
    parameter int                  PC_WIDTH   = 16,
    parameter int                  BR_TIMEOUT = 15,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                I_CLOCK,
    input  logic                I_RESET,
    input  logic                I_LOCK,
    input  logic                I_BranchStallSignal,
    input  logic                I_DepStallSignal,
    input  logic                I_GPUStallSignal,
    input  logic                I_BranchAddrSelect,
    input  logic [PC_WIDTH-1:0] I_BranchPC,
    output logic [PC_WIDTH-1:0] O_PC,
    output logic                O_HoldLatch,
    output logic                O_Bubble,
    output logic                O_FE_Valid,
    output logic [2:0]          O_State,
    output logic                O_BrTimeout
`ifdef FETCH_SCHED_PERF_EN
    ,
    output logic [31:0]         O_StallCycles,
    output logic [31:0]         O_BubbleCycles
`endif
);

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_BR_WAIT  = 3'd1,
        S_DEP_HOLD = 3'd2,
        S_GPU_HOLD = 3'd3,
        S_REDIRECT = 3'd4
    } state_t;

    localparam logic [7:0]          CNT_LAST = 8'(BR_TIMEOUT - 1);
    localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4);

    state_t     state;
    state_t     ret_state;
    logic [7:0] cnt;

    assign O_State = state;

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET || !I_LOCK) begin
            O_PC        <= RESET_PC;
            state       <= S_RUN;
            ret_state   <= S_RUN;
            cnt         <= '0;
            O_HoldLatch <= 1'b0;
            O_Bubble    <= 1'b0;
            O_FE_Valid  <= 1'b0;
            if (I_RESET)
                O_BrTimeout <= 1'b0;
        end else if (I_BranchAddrSelect) begin
            O_PC        <= I_BranchPC;
            state       <= S_REDIRECT;
            cnt         <= '0;
            O_HoldLatch <= 1'b0;
            O_Bubble    <= 1'b0;
            O_FE_Valid  <= 1'b1;
        end else if (I_GPUStallSignal || I_DepStallSignal) begin
            // Moving between the two hold states keeps the original return target.
            if (state != S_GPU_HOLD && state != S_DEP_HOLD)
                ret_state <= (state == S_BR_WAIT) ? S_BR_WAIT : S_RUN;
            state       <= I_GPUStallSignal ? S_GPU_HOLD : S_DEP_HOLD;
            O_HoldLatch <= 1'b1;
            O_Bubble    <= 1'b0;
            if (!I_GPUStallSignal)
                O_FE_Valid <= 1'b1;
        end else begin
            case (state)
                S_RUN, S_REDIRECT: begin
                    O_HoldLatch <= 1'b0;
                    if (I_BranchStallSignal) begin
                        state      <= S_BR_WAIT;
                        cnt        <= '0;
                        O_Bubble   <= 1'b1;
                        O_FE_Valid <= 1'b0;
                    end else begin
                        O_PC       <= O_PC + PC_STEP;
                        state      <= S_RUN;
                        O_Bubble   <= 1'b0;
                        O_FE_Valid <= 1'b1;
                    end
                end
                S_BR_WAIT: begin
                    O_HoldLatch <= 1'b0;
                    if (cnt == CNT_LAST) begin
                        // Give up on the branch and fall through to the next sequential PC.
                        O_BrTimeout <= 1'b1;
                        O_PC        <= O_PC + PC_STEP;
                        state       <= S_RUN;
                        cnt         <= '0;
                        O_Bubble    <= 1'b0;
                        O_FE_Valid  <= 1'b1;
                    end else begin
                        cnt        <= cnt + 8'd1;
                        O_Bubble   <= 1'b1;
                        O_FE_Valid <= 1'b0;
                    end
                end
                S_DEP_HOLD, S_GPU_HOLD: begin
                    state       <= ret_state;
                    O_HoldLatch <= 1'b0;
                    if (ret_state == S_BR_WAIT) begin
                        O_Bubble   <= 1'b1;
                        O_FE_Valid <= 1'b0;
                    end else begin
                        O_Bubble   <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_RUN;
                    O_HoldLatch <= 1'b0;
                    O_Bubble    <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_SCHED_PERF_EN
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            O_StallCycles  <= '0;
            O_BubbleCycles <= '0;
        end else begin
            if (state == S_GPU_HOLD || state == S_DEP_HOLD)
                O_StallCycles <= O_StallCycles + 32'd1;
            if (O_Bubble)
                O_BubbleCycles <= O_BubbleCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sched.sv
// Bench for fetch_sched: directed vector table for the named scenarios, then random
// stimulus against a behavioural model of the sequencing rules.
module tb_fetch_sched;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst, lock, bst, dep, gpu, bsel;
    logic [15:0] bpc;
    logic [15:0] o_pc;
    logic        o_hold, o_bub, o_val, o_to;
    logic [2:0]  o_state;
`ifdef FETCH_SCHED_PERF_EN
    logic [31:0] o_stall_cyc, o_bub_cyc;
`endif

    int vectors    = 0;
    int miscompares = 0;

    fetch_sched #(.PC_WIDTH(16), .BR_TIMEOUT(TO), .RESET_PC(16'h0000)) dut (
        .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock),
        .I_BranchStallSignal(bst), .I_DepStallSignal(dep), .I_GPUStallSignal(gpu),
        .I_BranchAddrSelect(bsel), .I_BranchPC(bpc),
        .O_PC(o_pc), .O_HoldLatch(o_hold), .O_Bubble(o_bub), .O_FE_Valid(o_val),
        .O_State(o_state), .O_BrTimeout(o_to)
`ifdef FETCH_SCHED_PERF_EN
        , .O_StallCycles(o_stall_cyc), .O_BubbleCycles(o_bub_cyc)
`endif
    );

    always #5 clk = ~clk;

    // input bits {rst,lock,bst,dep,gpu,bsel}; flag bits {hold,bubble,valid,timeout}
    typedef struct {
        logic [5:0]  in;
        logic [15:0] bpc;
        logic [15:0] pc;
        logic [2:0]  st;
        logic [3:0]  fl;
    } vec_t;

    localparam logic [5:0] FREE = 6'b010000, RST = 6'b110000, BST = 6'b011000,
                           DEP = 6'b010100, GPU = 6'b010010, BSEL = 6'b010001, LK0 = 6'b000000;

    vec_t tbl[40];

    task automatic drive(input logic [5:0] in, input logic [15:0] pc_in);
        {rst, lock, bst, dep, gpu, bsel} = in;
        bpc = pc_in;
    endtask

    task automatic check(input string name, input logic [15:0] pc, input logic [2:0] st,
                         input logic [3:0] fl);
        vectors++;
        if ({o_pc, o_state, o_hold, o_bub, o_val, o_to} !== {pc, st, fl}) begin
            miscompares++;
            $display("FAIL %s: got pc=%h st=%0d hold/bub/val/to=%b%b%b%b, want pc=%h st=%0d hold/bub/val/to=%b",
                     name, o_pc, o_state, o_hold, o_bub, o_val, o_to, pc, st, fl);
        end
    endtask

    // Behavioural model: tracks how many branch-wait edges have elapsed and where a
    // stall should resume, rather than mirroring any encoded state register.
    logic [15:0] m_pc;
    logic [2:0]  m_mode;
    int          m_waited;
    bit          m_back_br, m_hold, m_bub, m_val, m_to;
    int unsigned m_stall, m_bcyc;

    task automatic model_step(input logic [5:0] in, input logic [15:0] tgt);
        logic r, l, b, d, g, s;
        bit   in_hold;
        {r, l, b, d, g, s} = in;
        in_hold = (m_mode == 3'd2) || (m_mode == 3'd3);
        if (r) begin
            m_stall = 0;
            m_bcyc  = 0;
        end else begin
            if (in_hold) m_stall++;
            if (m_bub)   m_bcyc++;
        end
        if (r || !l) begin
            m_pc = 16'h0000; m_mode = 3'd0; m_waited = 0; m_back_br = 0;
            m_hold = 0; m_bub = 0; m_val = 0;
            if (r) m_to = 0;
        end else if (s) begin
            m_pc = tgt; m_mode = 3'd4; m_waited = 0;
            m_hold = 0; m_bub = 0; m_val = 1;
        end else if (g || d) begin
            if (!in_hold) m_back_br = (m_mode == 3'd1);
            m_mode = g ? 3'd3 : 3'd2;
            m_hold = 1; m_bub = 0;
            if (!g) m_val = 1;
        end else if (m_mode == 3'd0 || m_mode == 3'd4) begin
            m_hold = 0;
            if (b) begin
                m_mode = 3'd1; m_waited = 0; m_bub = 1; m_val = 0;
            end else begin
                m_pc = m_pc + 16'd4; m_mode = 3'd0; m_bub = 0; m_val = 1;
            end
        end else if (m_mode == 3'd1) begin
            m_hold = 0;
            if (m_waited == TO - 1) begin
                m_to = 1; m_pc = m_pc + 16'd4; m_mode = 3'd0; m_waited = 0;
                m_bub = 0; m_val = 1;
            end else begin
                m_waited++; m_bub = 1; m_val = 0;
            end
        end else begin
            m_hold = 0;
            m_mode = m_back_br ? 3'd1 : 3'd0;
            if (m_back_br) begin m_bub = 1; m_val = 0; end
            else m_bub = 0;
        end
    endtask

    initial begin
        drive(RST, 16'h0);
        m_pc = 0; m_mode = 0; m_waited = 0; m_back_br = 0;
        m_hold = 0; m_bub = 0; m_val = 0; m_to = 0; m_stall = 0; m_bcyc = 0;

        // reset then free-run
        tbl[0]  = '{RST,  16'h0, 16'h0000, 3'd0, 4'b0000};
        tbl[1]  = '{FREE, 16'h0, 16'h0004, 3'd0, 4'b0010};
        tbl[2]  = '{FREE, 16'h0, 16'h0008, 3'd0, 4'b0010};
        tbl[3]  = '{FREE, 16'h0, 16'h000C, 3'd0, 4'b0010};
        tbl[4]  = '{FREE, 16'h0, 16'h0010, 3'd0, 4'b0010};
        // branch stall at PC=8, resolved to 0x40 after three bubbles
        tbl[5]  = '{RST,  16'h0, 16'h0000, 3'd0, 4'b0000};
        tbl[6]  = '{FREE, 16'h0, 16'h0004, 3'd0, 4'b0010};
        tbl[7]  = '{FREE, 16'h0, 16'h0008, 3'd0, 4'b0010};
        tbl[8]  = '{BST,  16'h0, 16'h0008, 3'd1, 4'b0100};
        tbl[9]  = '{FREE, 16'h0, 16'h0008, 3'd1, 4'b0100};
        tbl[10] = '{FREE, 16'h0, 16'h0008, 3'd1, 4'b0100};
        tbl[11] = '{BSEL, 16'h0040, 16'h0040, 3'd4, 4'b0010};
        tbl[12] = '{FREE, 16'h0, 16'h0044, 3'd0, 4'b0010};
        // unresolved branch times out; sticky flag survives I_LOCK=0
        tbl[13] = '{BST,  16'h0, 16'h0044, 3'd1, 4'b0100};
        tbl[14] = '{FREE, 16'h0, 16'h0044, 3'd1, 4'b0100};
        tbl[15] = '{FREE, 16'h0, 16'h0044, 3'd1, 4'b0100};
        tbl[16] = '{FREE, 16'h0, 16'h0044, 3'd1, 4'b0100};
        tbl[17] = '{FREE, 16'h0, 16'h0048, 3'd0, 4'b0011};
        tbl[18] = '{LK0,  16'h0, 16'h0000, 3'd0, 4'b0001};
        tbl[19] = '{FREE, 16'h0, 16'h0004, 3'd0, 4'b0011};
        tbl[20] = '{RST,  16'h0, 16'h0000, 3'd0, 4'b0000};
        // GPU stall inside branch wait keeps the wait count
        tbl[21] = '{BST,  16'h0, 16'h0000, 3'd1, 4'b0100};
        tbl[22] = '{FREE, 16'h0, 16'h0000, 3'd1, 4'b0100};
        tbl[23] = '{GPU,  16'h0, 16'h0000, 3'd3, 4'b1000};
        tbl[24] = '{GPU,  16'h0, 16'h0000, 3'd3, 4'b1000};
        tbl[25] = '{GPU,  16'h0, 16'h0000, 3'd3, 4'b1000};
        tbl[26] = '{FREE, 16'h0, 16'h0000, 3'd1, 4'b0100};
        tbl[27] = '{FREE, 16'h0, 16'h0000, 3'd1, 4'b0100};
        tbl[28] = '{FREE, 16'h0, 16'h0000, 3'd1, 4'b0100};
        tbl[29] = '{FREE, 16'h0, 16'h0004, 3'd0, 4'b0011};
        // redirect beats simultaneous GPU and dep stalls
        tbl[30] = '{GPU|DEP|BSEL, 16'h0100, 16'h0100, 3'd4, 4'b0011};
        tbl[31] = '{FREE, 16'h0, 16'h0104, 3'd0, 4'b0011};
        // PC wrap, then reset in the middle of a dep hold
        tbl[32] = '{BSEL, 16'hFFF8, 16'hFFF8, 3'd4, 4'b0011};
        tbl[33] = '{FREE, 16'h0, 16'hFFFC, 3'd0, 4'b0011};
        tbl[34] = '{FREE, 16'h0, 16'h0000, 3'd0, 4'b0011};
        tbl[35] = '{DEP,  16'h0, 16'h0000, 3'd2, 4'b1011};
        tbl[36] = '{RST|DEP, 16'h0, 16'h0000, 3'd0, 4'b0000};
        tbl[37] = '{DEP,  16'h0, 16'h0000, 3'd2, 4'b1010};
        tbl[38] = '{FREE, 16'h0, 16'h0000, 3'd0, 4'b0010};
        tbl[39] = '{FREE, 16'h0, 16'h0004, 3'd0, 4'b0010};

        for (int i = 0; i < 40; i++) begin
            drive(tbl[i].in, tbl[i].bpc);
            @(negedge clk);
            #1;
            check($sformatf("tbl[%0d]", i), tbl[i].pc, tbl[i].st, tbl[i].fl);
        end

        for (int n = 0; n < 3000; n++) begin
            logic [5:0]  in;
            logic [15:0] tgt;
            in[5] = (n == 0) || ($urandom_range(63) == 0);
            in[4] = ($urandom_range(31) != 0);
            in[3] = ($urandom_range(2) == 0);
            in[2] = ($urandom_range(5) == 0);
            in[1] = ($urandom_range(5) == 0);
            in[0] = ($urandom_range(9) == 0);
            tgt   = 16'($urandom);
            drive(in, tgt);
            model_step(in, tgt);
            @(negedge clk);
            #1;
            check($sformatf("rnd[%0d]", n), m_pc, m_mode, {m_hold, m_bub, m_val, m_to});
`ifdef FETCH_SCHED_PERF_EN
            vectors++;
            if (o_stall_cyc !== m_stall || o_bub_cyc !== m_bcyc) begin
                miscompares++;
                $display("FAIL perf[%0d]: got stall=%0d bubble=%0d, want stall=%0d bubble=%0d",
                         n, o_stall_cyc, o_bub_cyc, m_stall, m_bcyc);
            end
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
